// File: rtl/dct_transpose_sched.sv
// Ping-pong 8x8 transpose buffer between the row and column 1-D DCT passes.
// Rows from the first pass fill the write bank; a full bank is replayed
// column by column through a single registered output stage.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   di[8], di_valid      row of coefficients from the first pass (di[j] = column j)
//   di_cnt               row index claimed by the first pass (checked, not used for addressing)
//   di_hold              stall to the first pass (only with di_valid)
//   q[8], q_valid        column to the second pass (q[j] = row j), registered
//   q_cnt                column index of q, registered
//   q_hold               stall from the second pass
//   bank_level           number of full banks, 0..2
//   seq_err              sticky row-index mismatch flag
module dct_transpose_sched #(
    parameter int unsigned DW        = 12,
    parameter int unsigned CHECK_CNT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0][DW-1:0] di,
    input  logic               di_valid,
    output logic               di_hold,
    input  logic [2:0]         di_cnt,
    output logic [7:0][DW-1:0] q,
    output logic               q_valid,
    input  logic               q_hold,
    output logic [2:0]         q_cnt,
    output logic [1:0]         bank_level,
    output logic               seq_err
);

    localparam int unsigned NROW = 8;

    // Buffer: bank, row; each entry holds one full row of coefficients.
    logic [7:0][DW-1:0] mem [2][NROW];

    logic [1:0]         full;
    logic [1:0]         full_nxt;
    logic               wb;
    logic               rb;
    logic [2:0]         wr_row;
    logic [2:0]         rd_col;
    logic               wr_fire;
    logic               rd_load;
    logic [7:0][DW-1:0] col_rd;

    assign di_hold    = di_valid & full[wb];
    assign wr_fire    = di_valid & ~full[wb];
    // The output register is free when it is empty or its beat is being taken.
    assign rd_load    = full[rb] & ~(q_valid & q_hold);
    assign bank_level = 2'(full[0]) + 2'(full[1]);

    // Gather one column of the read bank.
    always_comb begin
        col_rd = '0;
        for (int j = 0; j < 8; j++) begin
            col_rd[j] = mem[rb][3'(j)][rd_col];
        end
    end

    // Bank occupancy: set on the last row written, cleared on the last column
    // loaded. Set needs full=0 and clear needs full=1, so they never collide.
    always_comb begin
        full_nxt = full;
        if (wr_fire && wr_row == 3'd7) begin
            full_nxt[wb] = 1'b1;
        end
        if (rd_load && rd_col == 3'd7) begin
            full_nxt[rb] = 1'b0;
        end
    end

    // Control state and output stage.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            full    <= '0;
            wb      <= 1'b0;
            rb      <= 1'b0;
            wr_row  <= '0;
            rd_col  <= '0;
            q       <= '0;
            q_cnt   <= '0;
            q_valid <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_row <= wr_row + 3'd1;
                if (wr_row == 3'd7) begin
                    wb <= ~wb;
                end
                if (CHECK_CNT != 0 && di_cnt != wr_row) begin
                    seq_err <= 1'b1;
                end
            end
            if (rd_load) begin
                q       <= col_rd;
                q_cnt   <= rd_col;
                q_valid <= 1'b1;
                rd_col  <= rd_col + 3'd1;
                if (rd_col == 3'd7) begin
                    rb <= ~rb;
                end
            end else if (!q_hold) begin
                q_valid <= 1'b0;
            end
        end
    end

    // Row storage; always addressed by the internal row counter.
    always_ff @(posedge clk) begin
        if (resetn && wr_fire) begin
            mem[wb][wr_row] <= di;
        end
    end

endmodule
